// File: rtl/cp0_except_unit_pkg.sv
// CP0 exception unit shared definitions.
// Register map, field positions, ExcCodes and the pipe exception bundle.
package cp0_except_unit_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM  = 8;

  localparam int CA_EXC = 2;
  localparam int CA_IP  = 8;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_e;

  typedef struct packed {
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Overflow;
    logic Syscall;
    logic Break;
    logic WrongAddressinMEM;
  } ExceptinPipeType;

  function automatic logic [31:0] merge_wr(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [31:0] mask
  );
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Count advances every second cycle; TI latches on match until Compare is written.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        tog;
  logic [31:0] count_nxt;
  logic [31:0] compare_nxt;

  // next Count/Compare: a write beats the half-rate increment
  always_comb begin
    count_nxt   = count;
    compare_nxt = compare;
    if (count_wr)
      count_nxt = wr_data;
    else if (tog)
      count_nxt = count + 32'd1;
    if (compare_wr)
      compare_nxt = wr_data;
  end

  // timer state and sticky match flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog     <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      tog     <= ~tog;
      count   <= count_nxt;
      compare <= compare_nxt;
      ti      <= compare_wr ? 1'b0
               : (ti | (count_nxt == compare_nxt));
    end
  end

endmodule

// File: rtl/cp0_except_unit.sv
// Precise exception resolution at MEM plus CP0 register file.
// Drives flush/redirect combinationally; CP0 state updates on the next edge.
module cp0_except_unit
  import cp0_except_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM_Valid,
  input  ExceptinPipeType MEM_ExceptType,
  input  logic [31:0]     MEM_PC,
  input  logic [31:0]     MEM_ALUOut,
  input  logic            MEM_DMWr,
  input  logic            MEM_InDelaySlot,
  input  logic            MEM_IsEret,
  input  logic [5:0]      HW_Int,
  input  logic [4:0]      CP0_RdAddr,
  output logic [31:0]     CP0_RdData,
  input  logic            WB_CP0Wr,
  input  logic [4:0]      WB_Dst,
  input  logic [31:0]     WB_OutB,
  output logic            MEM_Flush,
  output logic            Redirect,
  output logic [31:0]     RedirectPC,
  output logic            TimerInt
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] cause;
  logic [4:0]  exc_code;
  logic        bd;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic        ti;
  logic [7:0]  ip;

  logic        valid;
  logic        irq;
  logic        exc_take;
  exc_code_e   exc_sel;
  logic        bad_pc;
  logic        bad_alu;
  logic        eret;
  logic [31:0] epc_fwd;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  assign valid      = MEM_Valid & rst;
  assign wr_count   = WB_CP0Wr & (WB_Dst == CP0_COUNT);
  assign wr_compare = WB_CP0Wr & (WB_Dst == CP0_COMPARE);
  assign wr_status  = WB_CP0Wr & (WB_Dst == CP0_STATUS);
  assign wr_cause   = WB_CP0Wr & (WB_Dst == CP0_CAUSE);
  assign wr_epc     = WB_CP0Wr & (WB_Dst == CP0_EPC);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_wr   (wr_count),
    .compare_wr (wr_compare),
    .wr_data    (WB_OutB),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  assign ip       = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign TimerInt = ti;

  // architectural Cause view
  always_comb begin
    cause             = '0;
    cause[CA_BD]      = bd;
    cause[CA_TI]      = ti;
    cause[CA_IP +: 8] = ip;
    cause[CA_EXC +: 5] = exc_code;
  end

  assign irq = status[ST_IE] & ~status[ST_EXL]
             & (|(ip & status[ST_IM +: 8])) & valid;

  // one precise exception per cycle, highest priority first
  always_comb begin
    exc_take = 1'b1;
    exc_sel  = EXC_INT;
    bad_pc   = 1'b0;
    bad_alu  = 1'b0;
    priority case (1'b1)
      irq: exc_sel = EXC_INT;
      valid & MEM_ExceptType.WrongAddressinIF: begin
        exc_sel = EXC_ADEL;
        bad_pc  = 1'b1;
      end
      valid & MEM_ExceptType.ReservedInstruction: exc_sel = EXC_RI;
      valid & MEM_ExceptType.Overflow:            exc_sel = EXC_OV;
      valid & MEM_ExceptType.Syscall:             exc_sel = EXC_SYS;
      valid & MEM_ExceptType.Break:               exc_sel = EXC_BP;
      valid & MEM_ExceptType.WrongAddressinMEM: begin
        exc_sel = MEM_DMWr ? EXC_ADES : EXC_ADEL;
        bad_alu = 1'b1;
      end
      default: exc_take = 1'b0;
    endcase
  end

  assign eret       = valid & MEM_IsEret & ~exc_take;
  assign epc_fwd    = wr_epc ? WB_OutB : epc;
  assign MEM_Flush  = exc_take | eret;
  assign Redirect   = exc_take | eret;
  assign RedirectPC = eret ? epc_fwd : EXC_VECTOR;

  // CP0 state: MTC0, then exception/ERET, then hardware IP sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= STATUS_RST;
      epc      <= '0;
      badvaddr <= '0;
      exc_code <= '0;
      bd       <= 1'b0;
      ip_sw    <= '0;
      ip_hw    <= '0;
    end else begin
      if (wr_status)
        status <= merge_wr(status, WB_OutB, STATUS_WMASK);
      if (wr_cause)
        ip_sw <= WB_OutB[9:8];
      if (wr_epc)
        epc <= WB_OutB;
      if (exc_take) begin
        exc_code <= exc_sel;
        if (!status[ST_EXL]) begin
          epc <= MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
          bd  <= MEM_InDelaySlot;
        end
        status[ST_EXL] <= 1'b1;
        if (bad_pc)
          badvaddr <= MEM_PC;
        else if (bad_alu)
          badvaddr <= MEM_ALUOut;
      end else if (eret) begin
        status[ST_EXL] <= 1'b0;
      end
      ip_hw <= HW_Int;
    end
  end

  // MFC0 read with same-cycle MTC0 bypass
  always_comb begin
    CP0_RdData = '0;
    unique case (CP0_RdAddr)
      CP0_BADVADDR: CP0_RdData = badvaddr;
      CP0_COUNT:    CP0_RdData = wr_count ? WB_OutB : count;
      CP0_COMPARE:  CP0_RdData = wr_compare ? WB_OutB : compare;
      CP0_STATUS:
        CP0_RdData = wr_status
                   ? merge_wr(status, WB_OutB, STATUS_WMASK)
                   : status;
      CP0_CAUSE:
        CP0_RdData = wr_cause
                   ? merge_wr(cause, WB_OutB, CAUSE_WMASK)
                   : cause;
      CP0_EPC:      CP0_RdData = epc_fwd;
      default:      CP0_RdData = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_except_unit.sv
// Directed and random stimulus for cp0_except_unit.
// Expectations come from an architectural CP0 model kept in the bench.
module tb_cp0_except_unit;
  import cp0_except_unit_pkg::*;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] SRST = 32'h0040_0000;
  localparam logic [31:0] SMSK = 32'h0000_FF03;

  logic            clk;
  logic            rst;
  logic            MEM_Valid;
  ExceptinPipeType et;
  logic [31:0]     MEM_PC;
  logic [31:0]     MEM_ALUOut;
  logic            MEM_DMWr;
  logic            MEM_InDelaySlot;
  logic            MEM_IsEret;
  logic [5:0]      HW_Int;
  logic [4:0]      CP0_RdAddr;
  logic [31:0]     CP0_RdData;
  logic            WB_CP0Wr;
  logic [4:0]      WB_Dst;
  logic [31:0]     WB_OutB;
  logic            MEM_Flush;
  logic            Redirect;
  logic [31:0]     RedirectPC;
  logic            TimerInt;

  cp0_except_unit #(.EXC_VECTOR(VEC), .STATUS_RST(SRST)) dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_Valid       (MEM_Valid),
    .MEM_ExceptType  (et),
    .MEM_PC          (MEM_PC),
    .MEM_ALUOut      (MEM_ALUOut),
    .MEM_DMWr        (MEM_DMWr),
    .MEM_InDelaySlot (MEM_InDelaySlot),
    .MEM_IsEret      (MEM_IsEret),
    .HW_Int          (HW_Int),
    .CP0_RdAddr      (CP0_RdAddr),
    .CP0_RdData      (CP0_RdData),
    .WB_CP0Wr        (WB_CP0Wr),
    .WB_Dst          (WB_Dst),
    .WB_OutB         (WB_OutB),
    .MEM_Flush       (MEM_Flush),
    .Redirect        (Redirect),
    .RedirectPC      (RedirectPC),
    .TimerInt        (TimerInt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // architectural model state
  logic [31:0] m_status, m_epc, m_bad, m_cnt, m_cmp;
  logic        m_ti, m_tog, m_bd;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_status = SRST; m_epc = 0; m_bad = 0; m_cnt = 0; m_cmp = 0;
    m_ti = 0; m_tog = 0; m_bd = 0; m_hw = 0; m_sw = 0; m_code = 0;
  endtask

  function automatic logic [31:0] cause_view(input logic [1:0] sw);
    return {m_bd, m_ti, 14'd0, m_hw[5] | m_ti, m_hw[4:0], sw,
            1'b0, m_code, 2'b00};
  endfunction

  // 0 none, 1 irq, 2 IF addr, 3 RI, 4 ov, 5 sys, 6 break, 7 MEM addr
  function automatic int exp_src();
    bit v;
    logic [7:0] pend;
    v = MEM_Valid && rst;
    pend = {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    if (!v) return 0;
    if (m_status[0] && !m_status[1] && (pend & m_status[15:8]) != 0)
      return 1;
    if (et.WrongAddressinIF)    return 2;
    if (et.ReservedInstruction) return 3;
    if (et.Overflow)            return 4;
    if (et.Syscall)             return 5;
    if (et.Break)               return 6;
    if (et.WrongAddressinMEM)   return 7;
    return 0;
  endfunction

  function automatic logic [4:0] code_of(input int s);
    case (s)
      2: return 5'h04;
      3: return 5'h0A;
      4: return 5'h0C;
      5: return 5'h08;
      6: return 5'h09;
      7: return MEM_DMWr ? 5'h05 : 5'h04;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    bit byp;
    byp = WB_CP0Wr && (WB_Dst == a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return byp ? WB_OutB : m_cnt;
      5'd11: return byp ? WB_OutB : m_cmp;
      5'd12: return byp ? ((m_status & ~SMSK) | (WB_OutB & SMSK))
                        : m_status;
      5'd13: return cause_view(byp ? WB_OutB[9:8] : m_sw);
      5'd14: return byp ? WB_OutB : m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    int s;
    bit er, fl;
    s  = exp_src();
    er = (s == 0) && MEM_Valid && rst && MEM_IsEret;
    fl = (s != 0) || er;
    chk("flush", MEM_Flush, fl);
    chk("redirect", Redirect, fl);
    if (fl)
      chk("redirect_pc", RedirectPC,
          (s != 0) ? VEC
          : ((WB_CP0Wr && WB_Dst == 5'd14) ? WB_OutB : m_epc));
    chk("rd_data", CP0_RdData, exp_rd(CP0_RdAddr));
    chk("timer_int", TimerInt, m_ti);
  endtask

  task automatic model_tick();
    int s;
    bit exl0, cw;
    logic [31:0] nc, ncmp;
    s    = exp_src();
    exl0 = m_status[1];
    cw   = WB_CP0Wr && WB_Dst == 5'd11;
    ncmp = cw ? WB_OutB : m_cmp;
    if (WB_CP0Wr && WB_Dst == 5'd9) nc = WB_OutB;
    else nc = m_tog ? m_cnt + 1 : m_cnt;
    m_ti  = cw ? 1'b0 : (m_ti | (nc == ncmp));
    m_cnt = nc;
    m_cmp = ncmp;
    m_tog = !m_tog;
    if (WB_CP0Wr) begin
      if (WB_Dst == 5'd12) m_status = (m_status & ~SMSK) | (WB_OutB & SMSK);
      if (WB_Dst == 5'd13) m_sw = WB_OutB[9:8];
      if (WB_Dst == 5'd14) m_epc = WB_OutB;
    end
    if (s != 0) begin
      m_code = code_of(s);
      if (!exl0) begin
        m_epc = MEM_InDelaySlot ? MEM_PC - 4 : MEM_PC;
        m_bd  = MEM_InDelaySlot;
      end
      m_status[1] = 1'b1;
      if (s == 2) m_bad = MEM_PC;
      if (s == 7) m_bad = MEM_ALUOut;
    end else if (MEM_Valid && MEM_IsEret) begin
      m_status[1] = 1'b0;
    end
    m_hw = HW_Int;
  endtask

  task automatic idle();
    MEM_Valid = 0; et = '0; MEM_PC = 0; MEM_ALUOut = 0; MEM_DMWr = 0;
    MEM_InDelaySlot = 0; MEM_IsEret = 0; HW_Int = 0; CP0_RdAddr = 0;
    WB_CP0Wr = 0; WB_Dst = 0; WB_OutB = 0;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    WB_CP0Wr = 0;
    CP0_RdAddr = a;
    #1;
    v = CP0_RdData;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    WB_CP0Wr = 1; WB_Dst = a; WB_OutB = d; CP0_RdAddr = a;
    step();
  endtask

  logic [31:0] v;
  logic [4:0]  addrs [8];

  initial begin
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};
    idle();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset values, MEM_Valid ignored while in reset
    MEM_Valid = 1; et.Overflow = 1; MEM_IsEret = 1;
    #1;
    chk("rst_flush", MEM_Flush, 0);
    chk("rst_redirect", Redirect, 0);
    rd(5'd12, v); chk("rst_status", v, SRST);
    rd(5'd13, v); chk("rst_cause", v, 0);
    rd(5'd14, v); chk("rst_epc", v, 0);
    chk("rst_ti", TimerInt, 0);
    @(negedge clk);
    idle();
    rst = 1;

    // timer: Compare=5 in the first cycle, TI at edge 10
    mtc0(5'd11, 32'd5);
    idle();
    CP0_RdAddr = 5'd9;
    repeat (8) step();
    chk("ti_edge9", TimerInt, 0);
    step();
    chk("ti_edge10", TimerInt, 1);
    rd(5'd9, v); chk("count_5", v, 5);

    // overflow, not in delay slot
    idle();
    MEM_Valid = 1; et.Overflow = 1; MEM_PC = 32'hBFC0_0100;
    #1;
    chk("ov_flush", MEM_Flush, 1);
    chk("ov_rpc", RedirectPC, VEC);
    step();
    idle();
    rd(5'd14, v); chk("ov_epc", v, 32'hBFC0_0100);
    rd(5'd13, v); chk("ov_code", (v >> 2) & 32'h1F, 32'h0C);
    rd(5'd12, v); chk("ov_exl", v[1], 1);

    idle(); MEM_Valid = 1; MEM_IsEret = 1; step();

    // store address error in a delay slot
    idle();
    MEM_Valid = 1; et.WrongAddressinMEM = 1; MEM_DMWr = 1;
    MEM_ALUOut = 32'h8000_0003; MEM_InDelaySlot = 1;
    MEM_PC = 32'hBFC0_0204;
    step();
    idle();
    rd(5'd13, v);
    chk("ades_code", (v >> 2) & 32'h1F, 32'h05);
    chk("ades_bd", v[31], 1);
    rd(5'd8, v);  chk("ades_bad", v, 32'h8000_0003);
    rd(5'd14, v); chk("ades_epc", v, 32'hBFC0_0200);

    idle(); MEM_Valid = 1; MEM_IsEret = 1; step();

    // hardware interrupt 0 with IE=1, IM2=1
    mtc0(5'd12, 32'h0000_0401);
    idle(); HW_Int = 6'd1; step();
    idle(); HW_Int = 6'd1; MEM_Valid = 1;
    #1;
    chk("int_redirect", Redirect, 1);
    chk("int_rpc", RedirectPC, VEC);
    step();
    idle(); HW_Int = 6'd1;
    rd(5'd13, v); chk("int_code", (v >> 2) & 32'h1F, 32'h00);
    MEM_Valid = 1;
    #1;
    chk("int_exl_block", MEM_Flush, 0);
    step();
    idle(); step();

    // ERET with same-cycle MTC0 EPC
    idle();
    MEM_Valid = 1; MEM_IsEret = 1;
    WB_CP0Wr = 1; WB_Dst = 5'd14; WB_OutB = 32'h8000_1000;
    #1;
    chk("eret_rpc", RedirectPC, 32'h8000_1000);
    chk("eret_redirect", Redirect, 1);
    step();
    idle();
    rd(5'd12, v); chk("eret_exl", v[1], 0);

    // RI beats Syscall; bubble with the same flags does nothing
    idle();
    MEM_Valid = 1; et.ReservedInstruction = 1; et.Syscall = 1;
    MEM_PC = 32'hBFC0_0300;
    step();
    idle();
    rd(5'd13, v); chk("ri_code", (v >> 2) & 32'h1F, 32'h0A);
    et.ReservedInstruction = 1; et.Syscall = 1;
    #1;
    chk("bubble_flush", MEM_Flush, 0);
    step();
    idle(); MEM_Valid = 1; MEM_IsEret = 1; step();

    // reset in the middle of an exception cycle
    idle();
    MEM_Valid = 1; et.Overflow = 1; MEM_PC = 32'hBFC0_0500;
    CP0_RdAddr = 5'd14;
    #1;
    chk("pre_rst_flush", MEM_Flush, 1);
    rst = 0;
    model_reset();
    #1;
    chk("mid_rst_flush", MEM_Flush, 0);
    chk("mid_rst_epc", CP0_RdData, 0);
    CP0_RdAddr = 5'd12;
    #1;
    chk("mid_rst_status", CP0_RdData, SRST);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      MEM_Valid = $urandom_range(0, 3) != 0;
      et = '0;
      if ($urandom_range(0, 3) == 0)
        et = ExceptinPipeType'(6'($urandom));
      MEM_PC = $urandom & 32'hFFFF_FFFC;
      MEM_ALUOut = $urandom;
      MEM_DMWr = 1'($urandom_range(0, 1));
      MEM_InDelaySlot = 1'($urandom_range(0, 1));
      MEM_IsEret = $urandom_range(0, 5) == 0;
      HW_Int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      WB_CP0Wr = $urandom_range(0, 3) == 0;
      WB_Dst = addrs[$urandom_range(0, 7)];
      WB_OutB = (WB_Dst == 5'd9 || WB_Dst == 5'd11)
              ? 32'($urandom_range(0, 15)) : $urandom;
      CP0_RdAddr = ($urandom_range(0, 2) == 0)
                 ? WB_Dst : addrs[$urandom_range(0, 7)];
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cp0_except_unit.md
# cp0_except_unit

Consumer end of the pipeline exception flow. Takes the `ExceptinPipeType` vector, PC and address carried into MEM, plus asynchronous interrupt lines, and decides on one precise exception per cycle. Maintains CP0 BadVAddr/Count/Compare/Status/Cause/EPC, serves MFC0 reads and MTC0 writes, and drives the pipeline flush and PC redirect.

## Interface

Parameters:
- `EXC_VECTOR`, default 32'hBFC0_0380: PC redirect target on exception entry.
- `STATUS_RST`, default 32'h0040_0000: Status reset value (BEV=1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `MEM_Valid` in 1: MEM holds a real instruction, not a bubble.
- `MEM_ExceptType` in `ExceptinPipeType`: exception flags accumulated up to MEM.
- `MEM_PC` in 32: byte PC of the MEM instruction.
- `MEM_ALUOut` in 32: data address computed by the MEM instruction.
- `MEM_DMWr` in 1: MEM instruction is a store. Selects AdES instead of AdEL for MEM address errors.
- `MEM_InDelaySlot` in 1: MEM instruction sits in a branch delay slot.
- `MEM_IsEret` in 1: MEM instruction is ERET.
- `HW_Int` in 6: external interrupt lines, level-sensitive.
- `CP0_RdAddr` in 5: MFC0 source register.
- `CP0_RdData` out 32: MFC0 read data, combinational.
- `WB_CP0Wr` in 1: MTC0 commit, from `RegsWrType.CP0Wr`.
- `WB_Dst` in 5: MTC0 destination register.
- `WB_OutB` in 32: MTC0 write data.
- `MEM_Flush` out 1: flush IF through MEM and write-disable MEM, combinational.
- `Redirect` out 1: load the PC with `RedirectPC`.
- `RedirectPC` out 32: new PC, either `EXC_VECTOR` or EPC.
- `TimerInt` out 1: Cause.TI, registered.

## Operation

- Registers (address): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other address reads 0.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. All other bits keep their reset value.
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: all 32 bits.
  - BadVAddr: read-only.
- Cause.IP[15:10] = `HW_Int` sampled each cycle. Cause.IP[15] is additionally ORed with TI.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM) & `MEM_Valid`.
- Exception priority, highest first, with ExcCode:
  1. Interrupt, 0x00.
  2. WrongAddressinIF, AdEL 0x04.
  3. ReservedInstruction, 0x0A.
  4. Overflow, 0x0C.
  5. Syscall, 0x08.
  6. Break, 0x09.
  7. WrongAddressinMEM: AdES 0x05 if `MEM_DMWr`, else AdEL 0x04.
- Flags count only when `MEM_Valid`.
- Exception taken, evaluated combinationally:
  - `MEM_Flush`=1, `Redirect`=1, `RedirectPC`=`EXC_VECTOR`.
  - At the next edge: ExcCode is set. If Status.EXL was 0, EPC = `MEM_InDelaySlot` ? `MEM_PC`-4 : `MEM_PC`, and BD = `MEM_InDelaySlot`. EXL is then set to 1.
  - BadVAddr = `MEM_PC` for an IF address error; `MEM_ALUOut` for a MEM address error; unchanged otherwise.
- ERET with no exception: `MEM_Flush`=1, `Redirect`=1, `RedirectPC`=EPC (MTC0 EPC bypassed). EXL is cleared at the next edge. An exception in the same cycle beats ERET.
- Count increments every second cycle using an internal toggle bit that resets to 0.
- Timer: TI is set when Count==Compare, held until an MTC0 to Compare, which clears it.
- Simultaneous events at one edge are applied in this order: MTC0 first, then the exception/ERET update on the fields it owns, then hardware IP sampling. The Count increment is suppressed in a cycle where MTC0 writes Count.
- `CP0_RdData` bypasses a same-cycle MTC0 to the same address, masked to its writable fields.

## Timing

- Reset values: Status=`STATUS_RST`; Cause, EPC, BadVAddr, Count, Compare = 0; toggle = 0; `TimerInt`=0; `MEM_Flush`, `Redirect` = 0 (MEM_Valid is ignored during reset).
- Decision latency is 0 cycles: flush and redirect are combinational in the cycle the instruction is in MEM.
- CP0 state is visible one cycle later.
- The interrupt check uses registered Status/Cause. An MTC0 enabling IE takes effect on the instruction after next; this is accepted.
- The next instruction reaching MEM after a flush sees EXL=1, so no nested interrupt occurs.
- Reset asserted mid-exception returns all state to reset values immediately, with no partial EPC write.

## Structure

- Shared package additions:
  - CP0 register-address constants.
  - ExcCode enum.
  - Status/Cause field-index constants.
  - `EXC_VECTOR` default.
- Sub-module `cp0_timer` holds Count, Compare, the toggle bit and TI. It takes write strobes and data, and outputs Count, Compare and TI.
- Priority encoding stays inline in the top module.

## Test plan

- Overflow at `MEM_PC`=0xBFC0_0100, not in a delay slot -> flush and redirect to 0xBFC0_0380 in the same cycle; next cycle EPC=0xBFC0_0100, ExcCode=0x0C, EXL=1.
- Store with WrongAddressinMEM, `MEM_ALUOut`=0x8000_0003, in a delay slot at PC 0xBFC0_0204 -> ExcCode=0x05, BadVAddr=0x8000_0003, EPC=0xBFC0_0200, BD=1.
- MTC0 Status=0x0000_0401, then `HW_Int`[0]=1 with a valid MEM instruction -> ExcCode=0x00, redirect taken. Repeat with EXL=1 -> no exception.
- ERET with EPC written by MTC0 in the same cycle to 0x8000_1000 -> `RedirectPC`=0x8000_1000 and EXL cleared.
- Compare=5, Count=0 -> TI rises when Count hits 5, i.e. 10 cycles after reset. MTC0 Compare clears TI.
- RI and Syscall set together -> ExcCode=0x0A; `MEM_Valid`=0 with the same flags -> no flush.
